int_issue_queue: RTL

INT_ISSUE_QUEUE -- requirements
Module: int_issue_queue

---
 rtl/int_issue_queue_if.sv | 45 ++++
 rtl/int_issue_queue.sv | 106 ++++++++++
 2 files changed

// File: rtl/int_issue_queue_if.sv
// Rename/scheduler-facing bundle for the integer issue queue.
// The scheduler-facing bundle carries allocation, dispatch, wakeup and flush, plus the registered per-entry view.
interface int_issue_queue_if #(
    parameter int DEPTH     = 8,
    parameter int IDX_W     = 3,
    parameter int TAG_W     = 6,
    parameter int AL_W      = 5,
    parameter int PAYLOAD_W = 72
);
    logic                                alloc_valid;
    logic                                alloc_ready;
    logic [TAG_W-1:0]                    alloc_src1;
    logic [TAG_W-1:0]                    alloc_src2;
    logic                                alloc_src1_rdy;
    logic                                alloc_src2_rdy;
    logic [AL_W-1:0]                     alloc_al_id;
    logic [PAYLOAD_W-1:0]                alloc_payload;
    logic                                disp_valid;
    logic [IDX_W-1:0]                    disp_index;
    logic [1:0]                          wk_valid;
    logic [1:0][TAG_W-1:0]               wk_tag;
    logic                                flush;
    logic [DEPTH-1:0]                    entry_available_bit;
    logic [DEPTH-1:0]                    ready_bit_src1;
    logic [DEPTH-1:0]                    ready_bit_src2;
    logic [DEPTH-1:0][TAG_W-1:0]         src1;
    logic [DEPTH-1:0][TAG_W-1:0]         src2;
    logic [DEPTH-1:0][AL_W-1:0]          active_list_id;
    logic [DEPTH-1:0][PAYLOAD_W-1:0]     payload;
    logic [IDX_W:0]                      count;

    modport master (
        output alloc_valid, alloc_src1, alloc_src2, alloc_src1_rdy, alloc_src2_rdy,
               alloc_al_id, alloc_payload, disp_valid, disp_index, wk_valid, wk_tag, flush,
        input  alloc_ready, entry_available_bit, ready_bit_src1, ready_bit_src2,
               src1, src2, active_list_id, payload, count
    );

    modport slave (
        input  alloc_valid, alloc_src1, alloc_src2, alloc_src1_rdy, alloc_src2_rdy,
               alloc_al_id, alloc_payload, disp_valid, disp_index, wk_valid, wk_tag, flush,
        output alloc_ready, entry_available_bit, ready_bit_src1, ready_bit_src2,
               src1, src2, active_list_id, payload, count
    );
endinterface

// File: rtl/int_issue_queue.sv
// Integer issue queue: lowest-free-slot allocation, two-port tag wakeup with
// same-cycle allocation bypass, indexed dispatch and whole-queue flush.
module int_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int IDX_W     = 3,
    parameter int TAG_W     = 6,
    parameter int AL_W      = 5,
    parameter int PAYLOAD_W = 72
) (
    input logic              clk,
    input logic              rst,
    int_issue_queue_if.slave bus
);
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0]                r_avail;
    logic [DEPTH-1:0]                r_rdy1;
    logic [DEPTH-1:0]                r_rdy2;
    logic [DEPTH-1:0][TAG_W-1:0]     r_src1;
    logic [DEPTH-1:0][TAG_W-1:0]     r_src2;
    logic [DEPTH-1:0][AL_W-1:0]      r_alid;
    logic [DEPTH-1:0][PAYLOAD_W-1:0] r_payload;
    logic [IDX_W:0]                  r_count;

    logic             w_alloc_ready;
    logic             w_alloc_fire;
    logic             w_disp_fire;
    logic [IDX_W-1:0] w_alloc_idx;
    logic             w_new_rdy1;
    logic             w_new_rdy2;

    function automatic logic wk_hit(input logic [TAG_W-1:0]      tag,
                                    input logic [1:0]            v,
                                    input logic [1:0][TAG_W-1:0] t);
        return (v[0] && (t[0] == tag)) || (v[1] && (t[1] == tag));
    endfunction

    assign w_alloc_ready = (r_count != FULL_CNT);
    assign w_alloc_fire  = bus.alloc_valid & w_alloc_ready & ~bus.flush;
    assign w_disp_fire   = bus.disp_valid & ~r_avail[bus.disp_index] & ~bus.flush;
    assign w_new_rdy1    = bus.alloc_src1_rdy | wk_hit(bus.alloc_src1, bus.wk_valid, bus.wk_tag);
    assign w_new_rdy2    = bus.alloc_src2_rdy | wk_hit(bus.alloc_src2, bus.wk_valid, bus.wk_tag);

    // Target is picked from the registered free mask, so a slot freed this cycle waits a cycle.
    always_comb begin
        logic found;
        found       = 1'b0;
        w_alloc_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_avail[i] && !found) begin
                w_alloc_idx = IDX_W'(i);
                found       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_avail   <= '1;
            r_rdy1    <= '0;
            r_rdy2    <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_alid    <= '0;
            r_payload <= '0;
            r_count   <= '0;
        end else if (bus.flush) begin
            r_avail <= '1;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
            r_count <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!r_avail[i]) begin
                    if (wk_hit(r_src1[i], bus.wk_valid, bus.wk_tag)) r_rdy1[i] <= 1'b1;
                    if (wk_hit(r_src2[i], bus.wk_valid, bus.wk_tag)) r_rdy2[i] <= 1'b1;
                end
                if (w_disp_fire && (bus.disp_index == IDX_W'(i))) begin
                    r_avail[i] <= 1'b1;
                    r_rdy1[i]  <= 1'b0;
                    r_rdy2[i]  <= 1'b0;
                end
                if (w_alloc_fire && (w_alloc_idx == IDX_W'(i))) begin
                    r_avail[i]   <= 1'b0;
                    r_rdy1[i]    <= w_new_rdy1;
                    r_rdy2[i]    <= w_new_rdy2;
                    r_src1[i]    <= bus.alloc_src1;
                    r_src2[i]    <= bus.alloc_src2;
                    r_alid[i]    <= bus.alloc_al_id;
                    r_payload[i] <= bus.alloc_payload;
                end
            end
            r_count <= r_count + (IDX_W+1)'(w_alloc_fire) - (IDX_W+1)'(w_disp_fire);
        end
    end

    assign bus.alloc_ready         = w_alloc_ready;
    assign bus.entry_available_bit = r_avail;
    assign bus.ready_bit_src1      = r_rdy1;
    assign bus.ready_bit_src2      = r_rdy2;
    assign bus.src1                = r_src1;
    assign bus.src2                = r_src2;
    assign bus.active_list_id      = r_alid;
    assign bus.payload             = r_payload;
    assign bus.count               = r_count;
endmodule
